// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_seq_pkg
//  Description : Shared types and widths for the PLL lock sequencer and its
//                helpers.
//                  seq_state_t - sequencer state encoding
//                  DIV_W       - clock-enable divider width (/2 .. /16)
//                  LOSS_W      - lock-loss event counter width
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  // Explicit 2-bit encoding keeps the state register width fixed.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int DIV_W  = 4;
  localparam int LOSS_W = 8;

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for bringing asynchronous
//                level signals into the clk domain. Both stages clear to 0
//                on reset.
//  Ports       : clk   - destination clock
//                rst_n - synchronous active-low reset
//                d     - asynchronous input
//                q     - synchronized output (2 clk edges of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_sequencer
//  Description : Qualifies the PLL locked signal, sequences the core reset
//                and generates /2, /4, /8, /16 clock enables for the core.
//                Lock loss while running re-asserts core reset and is
//                counted (saturating) for debug.
//  Ports       : clk_sys       - system clock (PLL output)
//                rst_n         - synchronous active-low reset
//                pll_locked    - PLL lock, asynchronous to clk_sys
//                soft_reset    - core reset request, level, synchronous
//                core_reset    - active-high core reset (state != RUN)
//                ready         - high only in RUN
//                ce_div2..16   - single-cycle clock enables while in RUN
//                lock_loss_cnt - saturating count of RUN lock-loss events
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 256,
  parameter int CNT_W       = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              soft_reset,
  output logic              core_reset,
  output logic              ready,
  output logic              ce_div2,
  output logic              ce_div4,
  output logic              ce_div8,
  output logic              ce_div16,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);

  logic              lk;
  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DIV_W-1:0]  div;
  logic              in_run;

  // --------------------------------------------------------------------------
  // Lock synchronizer: the FSM only ever looks at the synchronized copy.
  // --------------------------------------------------------------------------
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  // --------------------------------------------------------------------------
  // Sequencer. The qualify and hold phases share one counter since they never
  // overlap. The divider is cleared on every edge that does not keep the
  // block in RUN, so each RUN entry starts with div=0 and the enables never
  // emit a truncated period.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      div           <= '0;
      lock_loss_cnt <= '0;
    end else begin
      div <= '0;
      case (state)
        WAIT_LOCK: begin
          if (lk) begin
            state <= QUALIFY;
            cnt   <= '0;
          end
        end

        QUALIFY: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (cnt == QUAL_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            state <= RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Lock loss takes precedence over a soft reset request.
          if (!lk) begin
            state <= WAIT_LOCK;
            if (lock_loss_cnt != '1) begin
              lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
            end
          end else if (soft_reset) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            div <= div + DIV_W'(1);
          end
        end

        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs decode directly from flops only, so they are glitch-free.
  // --------------------------------------------------------------------------
  assign in_run     = (state == RUN);
  assign core_reset = ~in_run;
  assign ready      = in_run;

  assign ce_div2  = in_run & div[0];
  assign ce_div4  = in_run & (&div[1:0]);
  assign ce_div8  = in_run & (&div[2:0]);
  assign ce_div16 = in_run & (&div[3:0]);

endmodule : pll_lock_sequencer
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_sequencer
//  Description : Directed self-checking bench for pll_lock_sequencer with
//                LOCK_STABLE=8, RESET_HOLD=4 (lock-to-RUN = 15 edges).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

  logic       clk_sys    = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       core_reset;
  logic       ready;
  logic       ce_div2;
  logic       ce_div4;
  logic       ce_div8;
  logic       ce_div16;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  pll_lock_sequencer #(
    .LOCK_STABLE (8),
    .RESET_HOLD  (4),
    .CNT_W       (16)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .core_reset    (core_reset),
    .ready         (ready),
    .ce_div2       (ce_div2),
    .ce_div4       (ce_div4),
    .ce_div8       (ce_div8),
    .ce_div16      (ce_div16),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Advance n rising edges; sample and drive 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Expected enables {ce_div16, ce_div8, ce_div4, ce_div2} at RUN cycle k.
  function automatic logic [3:0] ce_at(input int k);
    logic [3:0] v;
    v[0] = (k % 2)  == 1;
    v[1] = (k % 4)  == 3;
    v[2] = (k % 8)  == 7;
    v[3] = (k % 16) == 15;
    return v;
  endfunction

  task automatic chk(input string tag, input logic e_rst, input logic e_rdy,
                     input logic [3:0] e_ce, input logic [7:0] e_cnt);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {core_reset, ready, ce_div16, ce_div8, ce_div4, ce_div2, lock_loss_cnt};
    exp = {e_rst, e_rdy, e_ce, e_cnt};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed rst=%b rdy=%b ce16..2=%b cnt=%0d, expected rst=%b rdy=%b ce16..2=%b cnt=%0d",
             tag, obs[13], obs[12], obs[11:8], obs[7:0], e_rst, e_rdy, e_ce, e_cnt);
    end
  endtask

  task automatic chk_rst(input string tag, input logic [7:0] e_cnt);
    chk(tag, 1'b1, 1'b0, 4'b0000, e_cnt);
  endtask

  task automatic chk_run(input string tag, input int k, input logic [7:0] e_cnt);
    chk(tag, 1'b0, 1'b1, ce_at(k), e_cnt);
  endtask

  initial begin
    int exp_cnt;

    // ---------------- power-up reset with lock already high ----------------
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rst("powerup", 8'd0);
    end

    // ---------------- glitchy lock: high 5, low 1, high ----------------
    rst_n = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;          // next edge is edge 1 of the final rise
    tick(14);
    chk_rst("glitch_e14", 8'd0);
    tick();
    chk_run("glitch_e15", 0, 8'd0);

    // ---------------- reset from RUN, then clean lock ----------------
    rst_n = 1'b0;
    tick();
    chk_rst("rst_from_run", 8'd0);
    rst_n = 1'b1;
    tick(14);
    chk_rst("clean_e14", 8'd0);
    tick();
    chk_run("clean_e15", 0, 8'd0);
    for (int k = 1; k < 32; k++) begin
      tick();
      chk_run("clean_ce", k, 8'd0);
    end

    // ---------------- single-cycle soft_reset in RUN ----------------
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk_rst("soft_hold0", 8'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_rst("soft_hold", 8'd0);
    end
    tick();
    chk_run("soft_run0", 0, 8'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_run("soft_ce", k, 8'd0);
    end

    // ---------------- lock loss at RUN cycle 20 ----------------
    pll_locked = 1'b0;
    tick();
    chk_run("loss_e1", 21, 8'd0);
    tick();
    chk_run("loss_e2", 22, 8'd0);
    tick();
    chk_rst("loss_e3", 8'd1);
    pll_locked = 1'b1;
    tick(14);
    chk_rst("relock_e14", 8'd1);
    tick();
    chk_run("relock_e15", 0, 8'd1);

    // ---------------- soft_reset coincident with lock loss ----------------
    pll_locked = 1'b0;
    tick(2);
    soft_reset = 1'b1;          // FSM sees lk=0 on the same edge
    tick();
    soft_reset = 1'b0;
    chk_rst("soft_and_loss", 8'd2);
    tick(3);
    chk_rst("soft_and_loss_stay", 8'd2);

    // ---------------- saturation of lock_loss_cnt ----------------
    for (int n = 1; n <= 298; n++) begin
      pll_locked = 1'b1;
      tick(15);
      exp_cnt = (n + 1 > 255) ? 255 : n + 1;
      chk_run("sat_run", 0, 8'(exp_cnt));
      pll_locked = 1'b0;
      tick(3);
      exp_cnt = (n + 2 > 255) ? 255 : n + 2;
      chk_rst("sat_loss", 8'(exp_cnt));
    end

    // ---------------- reset in the middle of QUALIFY ----------------
    pll_locked = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick();
    chk_rst("rst_mid_qualify", 8'd0);
    rst_n = 1'b1;
    tick(14);
    chk_rst("post_rst_e14", 8'd0);
    tick();
    chk_run("post_rst_e15", 0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pll_lock_sequencer
`default_nettype wire
